// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory program loader.
package mips_pkg;

  // Loader session states.
  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN_H,
    LEN_L,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  // Marker byte that opens every load frame.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Default instruction-memory size in 32-bit words.
  localparam int IMEM_DEPTH_DEFAULT = 1024;

  // A frame length is usable when it is non-zero and fits in memory.
  function automatic logic len_ok(input logic [15:0] len, input int depth);
    return (len != 16'd0) && (32'(len) <= depth);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;

  // Loader side: consumes the byte stream, drives the memory write port.
  modport master (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  // Environment side: supplies bytes, receives memory writes.
  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Collects four bytes big-endian into a word and pulses word_valid for one
// cycle, the cycle after the fourth byte arrives.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] shift_reg;
  logic [1:0]  byte_cnt_reg;
  logic        word_valid_reg;
  logic [31:0] word_reg;

  // High when the byte arriving now completes the word.
  assign last_byte  = (byte_cnt_reg == 2'd3);
  assign word_valid = word_valid_reg;
  assign word_data  = word_reg;

  // Shift bytes in, count them, and register the completed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg      <= '0;
      byte_cnt_reg   <= '0;
      word_valid_reg <= 1'b0;
      word_reg       <= '0;
    end else begin
      word_valid_reg <= 1'b0;
      if (clear) begin
        shift_reg    <= '0;
        byte_cnt_reg <= '0;
      end else if (byte_valid) begin
        shift_reg    <= {shift_reg[15:0], byte_data};
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
        if (last_byte) begin
          word_valid_reg <= 1'b1;
          word_reg       <= {shift_reg, byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses a framed byte stream (sync, 16-bit word count,
// big-endian words, XOR checksum), writes the words into instruction memory
// and holds the core in reset until a load passes its checksum.
module prog_loader
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  prog_loader_if.master   bus,
  output logic            core_rst,
  output logic            busy,
  output logic            done,
  output logic            err
);

  loader_state_t state_reg, state_next;

  logic [7:0]  len_h_reg;
  logic [15:0] len_reg;
  logic [10:0] word_cnt_reg;
  logic [7:0]  csum_reg;

  logic        accept;
  logic        start_ok;
  logic [15:0] len_full;
  logic        last_word;
  logic        pk_last_byte;
  logic        pk_word_valid;
  logic [31:0] pk_word_data;

  assign accept   = bus.in_valid && bus.in_ready;
  assign start_ok = start && (state_reg == IDLE || state_reg == DONE || state_reg == ERR);
  assign len_full = {len_h_reg, bus.in_data};
  // The word being assembled is the final one of the frame.
  assign last_word = ({5'd0, word_cnt_reg} == (len_reg - 16'd1));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (accept && (state_reg == DATA)),
    .byte_data  (bus.in_data),
    .last_byte  (pk_last_byte),
    .word_valid (pk_word_valid),
    .word_data  (pk_word_data)
  );

  // The write strobe and data come straight from the packer's registers;
  // the address is the count of words already written.
  assign bus.imem_we    = pk_word_valid;
  assign bus.imem_wdata = pk_word_data;
  assign bus.imem_addr  = word_cnt_reg[9:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode from the accepted byte and session counters.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERR: if (start) state_next = SYNC;
      SYNC:  if (accept && bus.in_data == SYNC_BYTE) state_next = LEN_H;
      LEN_H: if (accept) state_next = LEN_L;
      LEN_L: if (accept) state_next = len_ok(len_full, IMEM_DEPTH) ? DATA : ERR;
      DATA:  if (accept && pk_last_byte && last_word) state_next = CSUM;
      CSUM:  if (accept) state_next = (bus.in_data == csum_reg) ? DONE : ERR;
      default: state_next = IDLE;
    endcase
  end

  // Status and handshake outputs decoded from the current state.
  always_comb begin
    bus.in_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    core_rst     = 1'b1;
    case (state_reg)
      SYNC, LEN_H, LEN_L, DATA, CSUM: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        core_rst = 1'b0;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  // Length capture, running checksum and written-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_h_reg    <= '0;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      csum_reg     <= '0;
    end else if (start_ok) begin
      len_h_reg    <= '0;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      csum_reg     <= '0;
    end else begin
      if (accept && state_reg == LEN_H) len_h_reg <= bus.in_data;
      if (accept && state_reg == LEN_L) len_reg <= len_full;
      if (accept && state_reg == DATA)  csum_reg <= csum_reg ^ bus.in_data;
      // Saturate at the memory size so the address can never wrap.
      if (pk_word_valid && (32'(word_cnt_reg) < IMEM_DEPTH)) begin
        word_cnt_reg <= word_cnt_reg + 11'd1;
      end
    end
  end

endmodule
